uart_frame_tx: RTL and testbench

UART_FRAME_TX -- requirements
Module: uart_frame_tx

---
 rtl/uart_frame_tx.sv | 119 +++++++++++
 tb/tb_uart_frame_tx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// Sends a 7-byte telemetry frame "D" + four ASCII digits + CR LF over an 8N1 UART line.
// Digits come from a BCD snapshot taken when start is accepted; non-BCD nibbles are sent as '?'.
module uart_frame_tx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] num,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
    localparam int unsigned CntW     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state;
    logic [CntW-1:0] cnt;
    logic [2:0]      bit_idx;
    logic [2:0]      byte_idx;
    logic [15:0]     snap;
    logic [7:0]      cur_byte;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    always_comb begin
        cur_byte = 8'h0A;
        unique case (byte_idx)
            3'd0:    cur_byte = 8'h44;
            3'd1:    cur_byte = digit_ascii(snap[15:12]);
            3'd2:    cur_byte = digit_ascii(snap[11:8]);
            3'd3:    cur_byte = digit_ascii(snap[7:4]);
            3'd4:    cur_byte = digit_ascii(snap[3:0]);
            3'd5:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            snap     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (start) begin
                        snap     <= num;
                        state    <= StStart;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                    end
                end
                StStart: begin
                    if (cnt == CntLast) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= StData;
                        tx      <= cur_byte[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StData: begin
                    if (cnt == CntLast) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= StStop;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt == CntLast) begin
                        cnt <= '0;
                        // Last byte: drop busy and raise done together on the first idle cycle.
                        if (byte_idx == 3'd6) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            tx    <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= StStart;
                            tx       <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx at CLK_FREQ=1000, BAUD=100 (10 clocks per bit).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num;
    logic        tx;
    logic        busy;
    logic        done;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    uart_frame_tx #(
        .CLK_FREQ(1000),
        .BAUD    (100)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .num  (num),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Caller sits on a falling edge; returns on the falling edge of frame cycle 1.
    task automatic launch(input logic [15:0] v, input string tag);
        start = 1'b1;
        num   = v;
        @(negedge clk);
        start = 1'b0;
        check({tag, " start bit"}, 32'(tx), 32'd0);
        check({tag, " busy rises"}, 32'(busy), 32'd1);
    endtask

    // Runs frame cycles 1..700 against the expected bytes, then checks cycle 701.
    task automatic capture(input logic [55:0] exp, input string tag, input bit disturb,
                           output int busy_cycles);
        logic [7:0] got [7];
        logic [7:0] eb;
        logic       expbit;
        int         bad   = 0;
        int         dones = 0;
        busy_cycles = 0;
        for (int c = 1; c <= 700; c++) begin
            int j, b, k;
            if (c > 1) @(negedge clk);
            j  = (c - 1) / 10;
            b  = j / 10;
            k  = j % 10;
            eb = exp[55 - 8*b -: 8];
            expbit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : eb[k-1];
            if (tx !== expbit) bad++;
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) dones++;
            if ((c - 1) % 10 == 5 && k >= 1 && k <= 8) got[b][k-1] = tx;
            if (disturb) begin
                if (c == 1) num = 16'h5555;
                if (c == 250) start = 1'b1;
                if (c == 251) start = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, " bad tx cycles"}, 32'(bad), 32'd0);
        check({tag, " early done"}, 32'(dones), 32'd0);
        for (int b = 0; b < 7; b++)
            check($sformatf("%s byte%0d", tag, b), 32'(got[b]), 32'(exp[55 - 8*b -: 8]));
        check({tag, " done at 701"}, 32'(done), 32'd1);
        check({tag, " busy low at 701"}, 32'(busy), 32'd0);
        check({tag, " tx idle at 701"}, 32'(tx), 32'd1);
    endtask

    initial begin
        int bc1, bc2, cnt_b, cnt_d;
        rst   = 1'b1;
        start = 1'b1;
        num   = 16'h1234;
        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("start during rst ignored", 32'(busy), 32'd0);

        launch(16'h0123, "f0123");
        capture(56'h44_30_31_32_33_0D_0A, "f0123", 1'b0, bc1);
        check("f0123 busy cycles", 32'(bc1), 32'd700);
        @(negedge clk);
        check("done one cycle", 32'(done), 32'd0);

        launch(16'h9AF0, "f9AF0");
        capture(56'h44_39_3F_3F_30_0D_0A, "f9AF0", 1'b0, bc1);
        @(negedge clk);

        launch(16'h0123, "snap");
        capture(56'h44_30_31_32_33_0D_0A, "snap", 1'b1, bc1);
        @(negedge clk);
        check("snap no second done", 32'(done), 32'd0);
        check("snap no second frame", 32'(busy), 32'd0);

        launch(16'h0042, "b2b1");
        capture(56'h44_30_30_34_32_0D_0A, "b2b1", 1'b0, bc1);
        launch(16'h0042, "b2b2");
        capture(56'h44_30_30_34_32_0D_0A, "b2b2", 1'b0, bc2);
        check("b2b total busy", 32'(bc1 + bc2), 32'd1400);
        @(negedge clk);

        launch(16'h0123, "abort");
        repeat (349) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort tx", 32'(tx), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        cnt_b = 0;
        cnt_d = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) cnt_b++;
            if (done !== 1'b0) cnt_d++;
        end
        check("abort no resume", 32'(cnt_b), 32'd0);
        check("abort no done", 32'(cnt_d), 32'd0);
        launch(16'h0123, "after");
        capture(56'h44_30_31_32_33_0D_0A, "after", 1'b0, bc1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
